rv_instr_split: RTL and testbench
=================================

Name: rv_instr_split

Overview:
Registered RV32I instruction field splitter. Captures a 32-bit instruction word and presents every raw field plus 32-bit sign-extended I- and S-class immediates one cycle later. Sits in front of the decode logic, which consumes register indices, opcode/funct fields and immediates from here. The 12-to-32 sign extension lives in a small reusable sub-module.

Parameters:
none; all widths are fixed by RV32I.

Ports:
iwClk  in  1  clock; rising edge active
iwnRst  in  1  reset; asynchronous, active-low
iwValid  in  1  capture enable; iwInstr is sampled when high
iwInstr  in  32  instruction word
owValid  out  1  registered copy of iwValid
owRs1  out  5  instr[19:15]
owRs2  out  5  instr[24:20]
owRd  out  5  instr[11:7]
owImmediate20  out  20  instr[31:12] (U/J raw field)
owImmediate12  out  12  instr[31:20] (I-class)
owImmediate12SClass  out  12  {instr[31:25], instr[11:7]} (S-class; branches also use it)
owOpCode  out  7  instr[6:0]
owFunct3  out  3  instr[14:12]
owFunct7  out  7  instr[31:25]
owImmediate12Extended  out  32  owImmediate12 sign-extended from bit 11
owImmediate12SClassExtended  out  32  owImmediate12SClass sign-extended from bit 11

Behaviour:
- Reset: asynchronous, active-low, on iwnRst.
  - While iwnRst is low, all outputs are 0 immediately, independent of iwClk. owValid is also 0.
  - This includes reset asserted mid-stream; the pending capture is discarded.
- First rising edge after iwnRst goes high behaves normally. There is no extra recovery cycle.
- Capture: on each rising iwClk with iwnRst high:
  - owValid <= iwValid.
  - If iwValid is 1, all field registers load from iwInstr.
  - If iwValid is 0, the field registers hold their previous values. Only owValid drops.
- Latency: exactly one cycle from iwInstr to all field outputs. Back-to-back valid words are accepted every cycle. There is no back-pressure.
- Field extraction is purely positional. It is independent of opcode; all fields are always produced, even when meaningless for the format.
- No legality checking is done here.
- Sign extension:
  - Output bits [31:12] are copies of input bit 11.
  - Output bits [11:0] equal the input.
  - Results are registered together with the raw fields, so there is no combinational path from iwInstr to any output.
- The extended outputs must always equal the sign extension of the registered 12-bit outputs, including after reset (both are 0).
- No X propagation: every register has a reset value of 0.

Decomposition:
- Shared package holds the bit-position constants for the RV32I fields: rs1 19:15, rs2 24:20, rd 11:7, funct3 14:12, funct7 31:25, opcode 6:0, imm12 31:20, imm20 31:12, S-class high 31:25 and low 11:7.
- The opcode and funct constants stay in the existing opcode/function macro files.
- One sub-module, rv_sext_12_32: combinational, 12-bit in, 32-bit out.
  - It is instantiated twice, once for the I-class immediate and once for the S-class immediate.
  - It is reused by decode elsewhere.

Test Plan:
- Reset behaviour: drive iwnRst=0 with iwInstr=0xFFFFFFFF, iwValid=1 and clock running -> every output is 0 (owImmediate12Extended=0x00000000).
  - Release reset, then present 0xFFF10093 (addi x1,x2,-1) -> next cycle: owValid=1, owOpCode=0x13, owRd=1, owFunct3=0, owRs1=2, owRs2=0x1F, owFunct7=0x7F, owImmediate12=0xFFF, owImmediate12Extended=0xFFFFFFFF, owImmediate20=0xFFF10.
- Positive S-class: 0x00532423 (sw x5,8(x6)) -> owOpCode=0x23, owRs1=6, owRs2=5, owFunct3=2, owImmediate12SClass=0x008, owImmediate12SClassExtended=0x00000008.
- Negative S-class: 0xFE000E23 (sb x0,-4(x0)) -> owImmediate12SClass=0xFFC, owImmediate12SClassExtended=0xFFFFFFFC, owFunct7=0x7F, owRd=0x1C.
- U-type and back-to-back capture: 0x123451B7 (lui x3,0x12345) in one cycle, followed immediately by 0x00532423 -> cycle 1: owImmediate20=0x12345, owRd=3, owOpCode=0x37; cycle 2: sw fields as in the positive S-class case.
- Hold and asynchronous reset:
  - Load 0xFFF10093, then drive iwValid=0 with iwInstr=0x00000000 for 3 cycles -> fields unchanged, owValid=0.
  - Then pulse iwnRst low between clock edges -> all outputs go to 0 before the next edge.

Source files
------------

// File: rtl/rv_instr_split_pkg.sv
// Bit positions of the RV32I instruction fields and a positional splitter
// shared by the field-splitter register stage.
package rv_instr_split_pkg;

  localparam int rs1Msb    = 19;
  localparam int rs1Lsb    = 15;
  localparam int rs2Msb    = 24;
  localparam int rs2Lsb    = 20;
  localparam int rdMsb     = 11;
  localparam int rdLsb     = 7;
  localparam int funct3Msb = 14;
  localparam int funct3Lsb = 12;
  localparam int funct7Msb = 31;
  localparam int funct7Lsb = 25;
  localparam int opCodeMsb = 6;
  localparam int opCodeLsb = 0;
  localparam int imm12Msb  = 31;
  localparam int imm12Lsb  = 20;
  localparam int imm20Msb  = 31;
  localparam int imm20Lsb  = 12;
  localparam int sHiMsb    = 31;
  localparam int sHiLsb    = 25;
  localparam int sLoMsb    = 11;
  localparam int sLoLsb    = 7;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [19:0] imm20;
    logic [11:0] imm12;
    logic [11:0] imm12S;
    logic [6:0]  opCode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } instrFields_t;

  // Extraction is purely positional; every field is produced regardless of format.
  function automatic instrFields_t splitInstr(input logic [31:0] instr);
    instrFields_t f;
    f.rs1    = instr[rs1Msb:rs1Lsb];
    f.rs2    = instr[rs2Msb:rs2Lsb];
    f.rd     = instr[rdMsb:rdLsb];
    f.imm20  = instr[imm20Msb:imm20Lsb];
    f.imm12  = instr[imm12Msb:imm12Lsb];
    f.imm12S = {instr[sHiMsb:sHiLsb], instr[sLoMsb:sLoLsb]};
    f.opCode = instr[opCodeMsb:opCodeLsb];
    f.funct3 = instr[funct3Msb:funct3Lsb];
    f.funct7 = instr[funct7Msb:funct7Lsb];
    return f;
  endfunction

endpackage

// File: rtl/rv_instr_split_sext.sv
// Combinational 12-to-32 bit sign extender, reused by decode.
module rv_sext_12_32 (
  input  logic [11:0] immediate,
  output logic [31:0] extended
);

  assign extended = {{20{immediate[11]}}, immediate};

endmodule

// File: rtl/rv_instr_split.sv
// Registered RV32I instruction field splitter: captures an instruction word
// and presents raw fields plus sign-extended I/S immediates one cycle later.
module rv_instr_split
  import rv_instr_split_pkg::*;
(
  input  logic        iwClk,
  input  logic        iwnRst,
  input  logic        iwValid,
  input  logic [31:0] iwInstr,
  output logic        owValid,
  output logic [4:0]  owRs1,
  output logic [4:0]  owRs2,
  output logic [4:0]  owRd,
  output logic [19:0] owImmediate20,
  output logic [11:0] owImmediate12,
  output logic [11:0] owImmediate12SClass,
  output logic [6:0]  owOpCode,
  output logic [2:0]  owFunct3,
  output logic [6:0]  owFunct7,
  output logic [31:0] owImmediate12Extended,
  output logic [31:0] owImmediate12SClassExtended
);

  instrFields_t fieldsQ;
  logic         validQ;

  // Fields only reload on a valid word; otherwise they hold and just valid drops.
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      validQ  <= 1'b0;
      fieldsQ <= '0;
    end else begin
      validQ <= iwValid;
      if (iwValid) begin
        fieldsQ <= splitInstr(iwInstr);
      end
    end
  end

  assign owValid             = validQ;
  assign owRs1               = fieldsQ.rs1;
  assign owRs2               = fieldsQ.rs2;
  assign owRd                = fieldsQ.rd;
  assign owImmediate20       = fieldsQ.imm20;
  assign owImmediate12       = fieldsQ.imm12;
  assign owImmediate12SClass = fieldsQ.imm12S;
  assign owOpCode            = fieldsQ.opCode;
  assign owFunct3            = fieldsQ.funct3;
  assign owFunct7            = fieldsQ.funct7;

  // Extending from the registered fields keeps both views consistent, reset included.
  rv_sext_12_32 sextIClass (
    .immediate (fieldsQ.imm12),
    .extended  (owImmediate12Extended)
  );

  rv_sext_12_32 sextSClass (
    .immediate (fieldsQ.imm12S),
    .extended  (owImmediate12SClassExtended)
  );

endmodule

// File: tb/tb_rv_instr_split.sv
// Directed testbench for rv_instr_split with hand-decoded instruction fields.
module tb_rv_instr_split;

  logic        iwClk;
  logic        iwnRst;
  logic        iwValid;
  logic [31:0] iwInstr;
  logic        owValid;
  logic [4:0]  owRs1;
  logic [4:0]  owRs2;
  logic [4:0]  owRd;
  logic [19:0] owImmediate20;
  logic [11:0] owImmediate12;
  logic [11:0] owImmediate12SClass;
  logic [6:0]  owOpCode;
  logic [2:0]  owFunct3;
  logic [6:0]  owFunct7;
  logic [31:0] owImmediate12Extended;
  logic [31:0] owImmediate12SClassExtended;

  int checkCount = 0;
  int passCount  = 0;

  logic [140:0] allOutputs;
  assign allOutputs = {owValid, owRs1, owRs2, owRd, owImmediate20, owImmediate12,
                       owImmediate12SClass, owOpCode, owFunct3, owFunct7,
                       owImmediate12Extended, owImmediate12SClassExtended};

  rv_instr_split dut (
    .iwClk                       (iwClk),
    .iwnRst                      (iwnRst),
    .iwValid                     (iwValid),
    .iwInstr                     (iwInstr),
    .owValid                     (owValid),
    .owRs1                       (owRs1),
    .owRs2                       (owRs2),
    .owRd                        (owRd),
    .owImmediate20               (owImmediate20),
    .owImmediate12               (owImmediate12),
    .owImmediate12SClass         (owImmediate12SClass),
    .owOpCode                    (owOpCode),
    .owFunct3                    (owFunct3),
    .owFunct7                    (owFunct7),
    .owImmediate12Extended       (owImmediate12Extended),
    .owImmediate12SClassExtended (owImmediate12SClassExtended)
  );

  initial iwClk = 1'b0;
  always #5 iwClk = ~iwClk;

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge iwClk);
    #1;
  endtask

  task automatic test_reset();
    iwnRst  = 1'b0;
    iwValid = 1'b1;
    iwInstr = 32'hFFFF_FFFF;
    #2;
    checkCount++;
    if (allOutputs !== '0) $display("[TB] FAIL reset_initial: got %h required 0", allOutputs);
    else passCount++;
    repeat (3) tick();
    checkCount++;
    if (allOutputs !== '0) $display("[TB] FAIL reset_clocked: got %h required 0", allOutputs);
    else passCount++;
    checkCount++;
    if (owImmediate12Extended !== 32'h0000_0000)
      $display("[TB] FAIL reset_imm12ext: got %h required 00000000", owImmediate12Extended);
    else passCount++;
  endtask

  task automatic test_addi();
    #2 iwnRst = 1'b1;
    iwValid = 1'b1;
    iwInstr = 32'hFFF1_0093;
    tick();
    checkCount++;
    if (owValid !== 1'b1) $display("[TB] FAIL addi_valid: got %b required 1", owValid);
    else passCount++;
    checkCount++;
    if ({owOpCode, owRd, owFunct3, owRs1, owRs2, owFunct7} !== {7'h13, 5'd1, 3'd0, 5'd2, 5'h1F, 7'h7F})
      $display("[TB] FAIL addi_fields: got op=%h rd=%h f3=%h rs1=%h rs2=%h f7=%h required op=13 rd=01 f3=0 rs1=02 rs2=1f f7=7f",
               owOpCode, owRd, owFunct3, owRs1, owRs2, owFunct7);
    else passCount++;
    checkCount++;
    if (owImmediate12 !== 12'hFFF) $display("[TB] FAIL addi_imm12: got %h required fff", owImmediate12);
    else passCount++;
    checkCount++;
    if (owImmediate12Extended !== 32'hFFFF_FFFF)
      $display("[TB] FAIL addi_imm12ext: got %h required ffffffff", owImmediate12Extended);
    else passCount++;
    checkCount++;
    if (owImmediate20 !== 20'hFFF10) $display("[TB] FAIL addi_imm20: got %h required fff10", owImmediate20);
    else passCount++;
    checkCount++;
    if ({owImmediate12SClass, owImmediate12SClassExtended} !== {12'hFE1, 32'hFFFF_FFE1})
      $display("[TB] FAIL addi_simm: got %h/%h required fe1/ffffffe1", owImmediate12SClass, owImmediate12SClassExtended);
    else passCount++;
  endtask

  task automatic test_s_class();
    iwValid = 1'b1;
    iwInstr = 32'h0053_2423;
    tick();
    checkCount++;
    if ({owOpCode, owRs1, owRs2, owFunct3} !== {7'h23, 5'd6, 5'd5, 3'd2})
      $display("[TB] FAIL sw_fields: got op=%h rs1=%h rs2=%h f3=%h required op=23 rs1=06 rs2=05 f3=2",
               owOpCode, owRs1, owRs2, owFunct3);
    else passCount++;
    checkCount++;
    if ({owImmediate12SClass, owImmediate12SClassExtended} !== {12'h008, 32'h0000_0008})
      $display("[TB] FAIL sw_simm: got %h/%h required 008/00000008", owImmediate12SClass, owImmediate12SClassExtended);
    else passCount++;
    checkCount++;
    if ({owImmediate12, owImmediate12Extended, owImmediate20} !== {12'h005, 32'h0000_0005, 20'h00532})
      $display("[TB] FAIL sw_imm: got %h/%h/%h required 005/00000005/00532",
               owImmediate12, owImmediate12Extended, owImmediate20);
    else passCount++;

    iwInstr = 32'hFE00_0E23;
    tick();
    checkCount++;
    if ({owImmediate12SClass, owImmediate12SClassExtended} !== {12'hFFC, 32'hFFFF_FFFC})
      $display("[TB] FAIL sb_simm: got %h/%h required ffc/fffffffc", owImmediate12SClass, owImmediate12SClassExtended);
    else passCount++;
    checkCount++;
    if ({owFunct7, owRd, owRs1, owRs2} !== {7'h7F, 5'h1C, 5'd0, 5'd0})
      $display("[TB] FAIL sb_fields: got f7=%h rd=%h rs1=%h rs2=%h required f7=7f rd=1c rs1=00 rs2=00",
               owFunct7, owRd, owRs1, owRs2);
    else passCount++;
    checkCount++;
    if (owImmediate12Extended !== 32'hFFFF_FFE0)
      $display("[TB] FAIL sb_imm12ext: got %h required ffffffe0", owImmediate12Extended);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    iwValid = 1'b1;
    iwInstr = 32'h1234_51B7;
    tick();
    iwInstr = 32'h0053_2423;
    checkCount++;
    if ({owImmediate20, owRd, owOpCode} !== {20'h12345, 5'd3, 7'h37})
      $display("[TB] FAIL lui_fields: got imm20=%h rd=%h op=%h required imm20=12345 rd=03 op=37",
               owImmediate20, owRd, owOpCode);
    else passCount++;
    checkCount++;
    if ({owFunct3, owRs1, owRs2, owFunct7, owImmediate12Extended} !== {3'd5, 5'd8, 5'd3, 7'h09, 32'h0000_0123})
      $display("[TB] FAIL lui_other: got f3=%h rs1=%h rs2=%h f7=%h immext=%h required f3=5 rs1=08 rs2=03 f7=09 immext=00000123",
               owFunct3, owRs1, owRs2, owFunct7, owImmediate12Extended);
    else passCount++;
    tick();
    checkCount++;
    if ({owValid, owOpCode, owRs1, owRs2, owFunct3, owImmediate12SClassExtended} !==
        {1'b1, 7'h23, 5'd6, 5'd5, 3'd2, 32'h0000_0008})
      $display("[TB] FAIL b2b_sw: got v=%b op=%h rs1=%h rs2=%h f3=%h simmext=%h required v=1 op=23 rs1=06 rs2=05 f3=2 simmext=00000008",
               owValid, owOpCode, owRs1, owRs2, owFunct3, owImmediate12SClassExtended);
    else passCount++;
  endtask

  task automatic test_hold_and_async_reset();
    logic [139:0] heldFields;
    iwValid = 1'b1;
    iwInstr = 32'hFFF1_0093;
    tick();
    iwValid = 1'b0;
    iwInstr = 32'h0000_0000;
    heldFields = {5'd2, 5'h1F, 5'd1, 20'hFFF10, 12'hFFF, 12'hFE1, 7'h13, 3'd0, 7'h7F,
                  32'hFFFF_FFFF, 32'hFFFF_FFE1};
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCount++;
      if (owValid !== 1'b0) $display("[TB] FAIL hold_valid_%0d: got %b required 0", i, owValid);
      else passCount++;
      checkCount++;
      if (allOutputs[139:0] !== heldFields)
        $display("[TB] FAIL hold_fields_%0d: got %h required %h", i, allOutputs[139:0], heldFields);
      else passCount++;
    end
    // A valid word is pending when reset pulses between edges; it must be discarded.
    iwValid = 1'b1;
    iwInstr = 32'h1234_51B7;
    #2 iwnRst = 1'b0;
    #1;
    checkCount++;
    if (allOutputs !== '0) $display("[TB] FAIL async_reset: got %h required 0", allOutputs);
    else passCount++;
    #2 iwnRst = 1'b1;
    #1;
    checkCount++;
    if (allOutputs !== '0) $display("[TB] FAIL reset_release_hold: got %h required 0", allOutputs);
    else passCount++;
    iwInstr = 32'h0053_2423;
    tick();
    checkCount++;
    if ({owValid, owOpCode, owRs1, owRs2, owImmediate12SClass} !== {1'b1, 7'h23, 5'd6, 5'd5, 12'h008})
      $display("[TB] FAIL post_reset_capture: got v=%b op=%h rs1=%h rs2=%h simm=%h required v=1 op=23 rs1=06 rs2=05 simm=008",
               owValid, owOpCode, owRs1, owRs2, owImmediate12SClass);
    else passCount++;
  endtask

  initial begin
    $display("[TB] starting rv_instr_split bench");
    test_reset();
    test_addi();
    test_s_class();
    test_back_to_back();
    test_hold_and_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
